// File: rtl/parc_imem_arbiter.sv
// Merges two instruction-fetch ports onto one memory port and steers in-order responses back.
// Optional round-robin priority: define IMEM_ARB_RR_EN (otherwise port 0 has fixed priority).
module parc_imem_arbiter #(
   parameter int unsigned REQ_SZ  = 67,
   parameter int unsigned RESP_SZ = 35,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CNT_W   = 3
) (
   input  logic               clk,
   input  logic               reset,

   input  logic [REQ_SZ-1:0]  imemreq0_msg,
   input  logic               imemreq0_val,
   output logic               imemreq0_rdy,
   output logic [RESP_SZ-1:0] imemresp0_msg,
   output logic               imemresp0_val,

   input  logic [REQ_SZ-1:0]  imemreq1_msg,
   input  logic               imemreq1_val,
   output logic               imemreq1_rdy,
   output logic [RESP_SZ-1:0] imemresp1_msg,
   output logic               imemresp1_val,

   output logic [REQ_SZ-1:0]  memreq_msg,
   output logic               memreq_val,
   input  logic               memreq_rdy,
   input  logic [RESP_SZ-1:0] memresp_msg,
   input  logic               memresp_val,

   output logic [CNT_W-1:0]   outstanding,
   output logic               err_spurious
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // One bit per routing entry: the port ID that issued that request.
   logic [DEPTH-1:0] ids_q;
   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;

   logic full;
   logic empty;
   logic any_val;
   logic ptr;
   logic grant0;
   logic grant1;
   logic can_issue;
   logic xfer;
   logic pop;
   logic head_id;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign any_val = imemreq0_val | imemreq1_val;

`ifdef IMEM_ARB_RR_EN
   logic ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) ptr_d = ~grant1;
   end

   always_ff @(posedge clk) begin
      if (!reset) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
`else
   assign ptr = 1'b0;
`endif

   // A lone requester always wins; on a tie the pointer decides.
   assign grant1    = imemreq1_val & (~imemreq0_val | ptr);
   assign grant0    = imemreq0_val & ~grant1;
   assign can_issue = ~full & memreq_rdy;

   assign imemreq0_rdy = reset & can_issue & grant0;
   assign imemreq1_rdy = reset & can_issue & grant1;
   assign memreq_val   = reset & any_val & ~full;
   assign memreq_msg   = grant1 ? imemreq1_msg : imemreq0_msg;

   assign xfer    = memreq_val & memreq_rdy;
   assign pop     = reset & memresp_val & ~empty;
   assign head_id = ids_q[head_q];

   assign imemresp0_msg = memresp_msg;
   assign imemresp1_msg = memresp_msg;
   assign imemresp0_val = pop & ~head_id;
   assign imemresp1_val = pop & head_id;

   assign outstanding  = count_q;
   assign err_spurious = err_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      err_d   = err_q;
      if (pop)  head_d = head_q + AW'(1);
      if (xfer) tail_d = tail_q + AW'(1);
      unique case ({xfer, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (memresp_val && empty) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ids_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (xfer) ids_q[tail_q] <= grant1;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_parc_imem_arbiter.sv
// Randomised and directed bench for parc_imem_arbiter against a queue-based routing model.
module tb_parc_imem_arbiter;

   localparam int REQ_SZ  = 67;
   localparam int RESP_SZ = 35;
   localparam int DEPTH   = 4;
   localparam int CNT_W   = 3;

   logic               clk = 1'b0;
   logic               reset;
   logic [REQ_SZ-1:0]  imemreq0_msg, imemreq1_msg, memreq_msg;
   logic               imemreq0_val, imemreq1_val, imemreq0_rdy, imemreq1_rdy;
   logic [RESP_SZ-1:0] imemresp0_msg, imemresp1_msg, memresp_msg;
   logic               imemresp0_val, imemresp1_val;
   logic               memreq_val, memreq_rdy, memresp_val;
   logic [CNT_W-1:0]   outstanding;
   logic               err_spurious;

   always #5 clk = ~clk;

   parc_imem_arbiter #(
      .REQ_SZ (REQ_SZ),
      .RESP_SZ(RESP_SZ),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .imemreq0_msg (imemreq0_msg),
      .imemreq0_val (imemreq0_val),
      .imemreq0_rdy (imemreq0_rdy),
      .imemresp0_msg(imemresp0_msg),
      .imemresp0_val(imemresp0_val),
      .imemreq1_msg (imemreq1_msg),
      .imemreq1_val (imemreq1_val),
      .imemreq1_rdy (imemreq1_rdy),
      .imemresp1_msg(imemresp1_msg),
      .imemresp1_val(imemresp1_val),
      .memreq_msg   (memreq_msg),
      .memreq_val   (memreq_val),
      .memreq_rdy   (memreq_rdy),
      .memresp_msg  (memresp_msg),
      .memresp_val  (memresp_val),
      .outstanding  (outstanding),
      .err_spurious (err_spurious)
   );

   int checks   = 0;
   int failures = 0;

   // Model state: IDs of issued, unanswered requests in issue order.
   int q[$];
   int prio_m = 0;
   bit err_m  = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit rst, input bit v0, input bit v1, input bit mrdy, input bit rv);
      logic [95:0] r0, r1, r2;
      int  winner;
      bit  full, e_val, e_rdy0, e_rdy1, e_r0, e_r1, do_pop;
      @(negedge clk);
      r0 = {$urandom, $urandom, $urandom};
      r1 = {$urandom, $urandom, $urandom};
      r2 = {$urandom, $urandom, $urandom};
      reset        = rst;
      imemreq0_val = v0;
      imemreq1_val = v1;
      imemreq0_msg = r0[REQ_SZ-1:0];
      imemreq1_msg = r1[REQ_SZ-1:0];
      memreq_rdy   = mrdy;
      memresp_val  = rv;
      memresp_msg  = r2[RESP_SZ-1:0];
      #1;
      if (v0 && v1) begin
`ifdef IMEM_ARB_RR_EN
         winner = prio_m;
`else
         winner = 0;
`endif
      end else begin
         winner = v1 ? 1 : 0;
      end
      full   = (q.size() == DEPTH);
      e_val  = rst && (v0 || v1) && !full;
      e_rdy0 = e_val && mrdy && winner == 0;
      e_rdy1 = e_val && mrdy && winner == 1;
      do_pop = rst && rv && q.size() != 0;
      e_r0   = 1'b0;
      e_r1   = 1'b0;
      if (do_pop) begin
         e_r0 = (q[0] == 0);
         e_r1 = (q[0] == 1);
      end
      chk("imemreq0_rdy", 128'(imemreq0_rdy), 128'(e_rdy0));
      chk("imemreq1_rdy", 128'(imemreq1_rdy), 128'(e_rdy1));
      chk("memreq_val", 128'(memreq_val), 128'(e_val));
      if (e_val)
         chk("memreq_msg", 128'(memreq_msg), 128'(winner == 1 ? r1[REQ_SZ-1:0] : r0[REQ_SZ-1:0]));
      chk("imemresp0_val", 128'(imemresp0_val), 128'(e_r0));
      chk("imemresp1_val", 128'(imemresp1_val), 128'(e_r1));
      chk("imemresp0_msg", 128'(imemresp0_msg), 128'(r2[RESP_SZ-1:0]));
      chk("imemresp1_msg", 128'(imemresp1_msg), 128'(r2[RESP_SZ-1:0]));
      chk("outstanding", 128'(outstanding), 128'(q.size()));
      chk("err_spurious", 128'(err_spurious), 128'(err_m));
      if (!rst) begin
         q.delete();
         prio_m = 0;
         err_m  = 1'b0;
      end else begin
         if (rv && q.size() == 0) err_m = 1'b1;
         if (do_pop) void'(q.pop_front());
         if (e_val && mrdy) begin
            q.push_back(winner);
            prio_m = 1 - winner;
         end
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 1, 1);
   endtask

   initial begin
      reset = 1'b0; imemreq0_val = 1'b0; imemreq1_val = 1'b0; memreq_rdy = 1'b0;
      memresp_val = 1'b0; imemreq0_msg = '0; imemreq1_msg = '0; memresp_msg = '0;
      repeat (2) @(posedge clk);

      // Reset state
      step(0, 1, 1, 1, 0);
      chk("rst_forces_rdy0", 128'(imemreq0_rdy), 128'(1'b0));
      chk("rst_forces_mval", 128'(memreq_val), 128'(1'b0));
      step(1, 0, 0, 1, 0);
      chk("rst_outstanding", 128'(outstanding), 128'(0));
      chk("rst_err", 128'(err_spurious), 128'(1'b0));

      // Full stall
      for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 1, 0);
      step(1, 1, 0, 1, 0);
      chk("stall_rdy0", 128'(imemreq0_rdy), 128'(1'b0));
      chk("stall_mval", 128'(memreq_val), 128'(1'b0));
      chk("stall_out", 128'(outstanding), 128'(4));
      step(1, 1, 0, 1, 1);
      chk("stall_pop_no_push", 128'(imemreq0_rdy), 128'(1'b0));
      chk("stall_pop_resp0", 128'(imemresp0_val), 128'(1'b1));
      step(1, 1, 0, 1, 0);
      chk("stall_release_rdy0", 128'(imemreq0_rdy), 128'(1'b1));
      chk("stall_release_out", 128'(outstanding), 128'(3));
      step(1, 1, 0, 1, 0);
      chk("stall_refull_rdy0", 128'(imemreq0_rdy), 128'(1'b0));
      drain(4);

      // Arbitration with both ports valid
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 1, 1, 0);
`ifdef IMEM_ARB_RR_EN
         chk("arb_rr_rdy1", 128'(imemreq1_rdy), 128'(i % 2));
`else
         chk("arb_fixed_rdy1", 128'(imemreq1_rdy), 128'(1'b0));
         chk("arb_fixed_rdy0", 128'(imemreq0_rdy), 128'(1'b1));
`endif
      end
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 1, 1);
`ifdef IMEM_ARB_RR_EN
         chk("arb_rr_resp1", 128'(imemresp1_val), 128'(i % 2));
`else
         chk("arb_fixed_resp0", 128'(imemresp0_val), 128'(1'b1));
`endif
      end

      // Back-pressure
      step(1, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 1, 0, 0);
         chk("bp_rdy0", 128'(imemreq0_rdy), 128'(1'b0));
         chk("bp_rdy1", 128'(imemreq1_rdy), 128'(1'b0));
         chk("bp_out", 128'(outstanding), 128'(1));
      end
      step(1, 1, 1, 1, 0);
`ifdef IMEM_ARB_RR_EN
      chk("bp_first_grant", 128'(imemreq1_rdy), 128'(1'b1));
`else
      chk("bp_first_grant", 128'(imemreq0_rdy), 128'(1'b1));
`endif
      drain(2);

      // Same-cycle push and pop
      step(1, 0, 1, 1, 0);
      step(1, 1, 0, 1, 0);
      step(1, 1, 0, 1, 1);
      chk("pp_resp1", 128'(imemresp1_val), 128'(1'b1));
      chk("pp_rdy0", 128'(imemreq0_rdy), 128'(1'b1));
      step(1, 0, 0, 1, 0);
      chk("pp_out", 128'(outstanding), 128'(2));
      step(1, 0, 0, 1, 1);
      chk("pp_order_a", 128'(imemresp0_val), 128'(1'b1));
      step(1, 0, 0, 1, 1);
      chk("pp_order_b", 128'(imemresp0_val), 128'(1'b1));

      // Spurious response, then reset
      step(1, 0, 0, 1, 1);
      chk("sp_resp0", 128'(imemresp0_val), 128'(1'b0));
      chk("sp_resp1", 128'(imemresp1_val), 128'(1'b0));
      step(1, 0, 0, 1, 0);
      chk("sp_err_set", 128'(err_spurious), 128'(1'b1));
      step(1, 0, 0, 1, 0);
      chk("sp_err_hold", 128'(err_spurious), 128'(1'b1));
      step(0, 0, 0, 1, 0);
      step(1, 1, 1, 1, 0);
      chk("sp_rst_err", 128'(err_spurious), 128'(1'b0));
      chk("sp_rst_out", 128'(outstanding), 128'(0));
      chk("sp_rst_ptr", 128'(imemreq0_rdy), 128'(1'b1));
      drain(1);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         bit rst, v0, v1, mrdy, rv;
         rst  = ($urandom_range(0, 299) != 0);
         v0   = $urandom_range(0, 1) == 1;
         v1   = $urandom_range(0, 1) == 1;
         mrdy = ($urandom_range(0, 3) != 0);
         rv   = (q.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
         step(rst, v0, v1, mrdy, rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parc_imem_arbiter.md
Name: parc_imem_arbiter

Overview:
- Merges the core's two instruction-fetch ports (imemreq0/imemreq1 with their responses) onto a single instruction-memory port.
- Sits directly downstream of the dual-fetch core, between it and the memory or cache.
- Keeps a FIFO of port IDs for outstanding requests, so in-order memory responses are steered back to the port that issued them.
- The core's response ports have no rdy; every response must be delivered on its arrival cycle.

Parameters:
- REQ_SZ, 67, request message width (VC_MEM_REQ_MSG_SZ(32,32)).
- RESP_SZ, 35, response message width (VC_MEM_RESP_MSG_SZ(32)).
- DEPTH, 4, maximum outstanding requests (routing FIFO entries); power of two, at least 2.
- CNT_W, 3, width of the outstanding count; log2(DEPTH)+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- imemreq0_msg  in  REQ_SZ  port-0 request.
- imemreq0_val  in  1  port-0 request valid.
- imemreq0_rdy  out  1  port-0 request accepted.
- imemresp0_msg  out  RESP_SZ  port-0 response.
- imemresp0_val  out  1  port-0 response valid.
- imemreq1_msg  in  REQ_SZ  port-1 request.
- imemreq1_val  in  1  port-1 request valid.
- imemreq1_rdy  out  1  port-1 request accepted.
- imemresp1_msg  out  RESP_SZ  port-1 response.
- imemresp1_val  out  1  port-1 response valid.
- memreq_msg  out  REQ_SZ  merged request to memory.
- memreq_val  out  1  merged request valid.
- memreq_rdy  in  1  memory accepts request.
- memresp_msg  in  RESP_SZ  memory response; always in order.
- memresp_val  in  1  memory response valid.
- outstanding  out  CNT_W  number of issued, unanswered requests.
- err_spurious  out  1  sticky: a response arrived with no outstanding request.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FIFO emptied; outstanding=0; err_spurious=0.
  - Priority pointer set to port 0.
  - While reset is low, all rdy and val outputs are forced to 0.
- Issue condition: can_issue = !full && memreq_rdy.
- Grant:
  - Only one requester valid: that requester is granted.
  - Both valid: the port named by the priority pointer is granted.
- Request handshake:
  - imemreqN_rdy = can_issue && grantN.
  - memreq_val = (imemreq0_val || imemreq1_val) && !full.
  - memreq_msg = granted port's message, passed through combinationally (no request latency).
- Transfer: a transfer occurs when memreq_val && memreq_rdy. On a transfer:
  - push the granted port ID into the FIFO;
  - the priority pointer moves to the non-granted port.
- Response routing:
  - When memresp_val and the FIFO is non-empty: pop the head. imemrespN_val=1 for the head ID only, in the same cycle (zero latency).
  - Both imemresp*_msg are always driven from memresp_msg.
- Spurious response (memresp_val while the FIFO is empty):
  - both resp vals stay 0; the response is dropped;
  - err_spurious is set and holds until reset.
- Simultaneous push and pop in one cycle:
  - count is unchanged; both pointers advance.
  - When full, a pop in the same cycle does not enable a push; full is evaluated on the registered count.
- Counters: FIFO pointers wrap modulo DEPTH; outstanding = count register, range 0..DEPTH.
- Reset mid-operation: in-flight IDs are discarded. Responses that arrive after reset to requests issued before it are counted as spurious; the environment must drain memory first.

Optional Feature:
- Macro IMEM_ARB_RR_EN.
- Defined: round-robin priority pointer, as described above.
- Undefined: fixed priority; port 0 always wins when both are valid, and the pointer register is not instantiated.

Test Plan:
- Arbitration, RR_EN defined:
  - Stimulus: both ports valid, memreq_rdy=1, memory latency 2.
  - Required: four transfers go port 0,1,0,1; responses return with imemresp0_val, imemresp1_val alternating in the same order; outstanding peaks at 2.
- Full stall:
  - Stimulus: DEPTH=4, memory holds responses; port 0 issues continuously.
  - Required: 4 requests accepted; cycle 5 has imemreq0_rdy=0, memreq_val=0, outstanding=4. Release one response: the next cycle accepts exactly one request.
- Same-cycle push and pop:
  - Stimulus: outstanding=2, then memresp_val and a new request in the same cycle.
  - Required: outstanding stays 2; routing matches the issue order.
- Back-pressure:
  - Stimulus: memreq_rdy=0 with both ports valid for 3 cycles.
  - Required: both rdy=0, no push, pointer unchanged; the first grant after rdy rises goes to the pointer port.
- Spurious response and reset:
  - Stimulus: memresp_val with an empty FIFO.
  - Required: both resp vals 0, err_spurious=1 and holding.
  - Then reset=0 for 1 cycle: err_spurious=0, outstanding=0, pointer at port 0.
- Fixed priority, RR_EN undefined:
  - Stimulus: both ports valid for 3 cycles.
  - Required: three port-0 transfers; imemreq1_rdy stays 0.
